display_mmio_reg: RTL and testbench
===================================

// Module: display_mmio_reg
// PURPOSE
//  Memory-mapped peripheral that sits between the CPU data bus and the seven-segment display driver.
//  CPU stores land in a shadow register. Committed values are pushed to data_display[23:0] at a bounded rate, so a tight store loop cannot make the tubes flicker.
//  Supports freeze (hold the current display) and read-back of all registers.
// PARAMETERS
//  BASE_ADDR   32'hFFFF_FC60  byte address of register 0; the block decodes BASE_ADDR+0/+4/+8 only
//  UPDATE_DIV  100_000        clk cycles between commit opportunities (refresh tick period); legal range >=2
// PORTS
//  clk           in   1   system clock; the only clock
//  rst           in   1   synchronous, active-high reset
//  addr          in   32  CPU byte address (word aligned; addr[1:0] ignored)
//  wdata         in   32  CPU store data
//  we            in   1   store strobe, one cycle per store
//  re            in   1   load strobe, one cycle per load
//  rdata         out  32  load data, valid the cycle after re
//  data_display  out  24  binary value fed to the display driver
// BEHAVIOUR
//  Register map:
//   - +0 VALUE  RW  [23:0] shadow value; wdata[31:24] ignored; reads return {8'h0, shadow}
//   - +4 CTRL   RW  [0] freeze; [31:1] read as 0
//   - +8 STATUS RO  [0] pending; [23:0]... no: [1] tick_seen (sticky, cleared on STATUS read); writes ignored
//  Address decode: hit = (addr[31:2] == BASE_ADDR[31:2] + k), k = 0..2. A miss ignores we and returns rdata = 0.
//  Reset (rst=1 at posedge): data_display, shadow, freeze, pending, tick_seen, tick counter and rdata are all 0. FSM goes to IDLE.
//  Tick counter:
//   - Counts 0..UPDATE_DIV-1 and wraps.
//   - tick = 1 for the single cycle where count == UPDATE_DIV-1.
//   - Free-running, unaffected by freeze.
//  FSM (2 states):
//   - IDLE: a VALUE write sets pending=1 and goes to PEND.
//   - PEND: on tick with freeze=0, data_display <= shadow (value held at the start of that cycle), pending <= 0, go to IDLE.
//   - PEND with freeze=1: stay in PEND; commit happens on the first tick after freeze clears.
//  Simultaneous events:
//   - VALUE write and committing tick in the same cycle: display gets the OLD shadow, the shadow takes the new value, and pending stays 1 (state stays PEND).
//   - CTRL write clearing freeze in the same cycle as a tick: no commit that cycle (freeze is sampled as a register).
//   - Write and read to the same register in the same cycle: rdata returns the pre-write value.
//  Latency:
//   - Store to display: 1 to UPDATE_DIV cycles, plus any frozen time.
//   - rdata: registered, 1 cycle after re. rdata goes to 0 the cycle after re=0.
//  tick_seen:
//   - Set on any commit.
//   - A STATUS read returns the current value and clears it the next cycle; a same-cycle commit wins and it stays set.
//  Reset mid-PEND: the pending value is discarded and the display returns to 0.
// STRUCTURE
//  Shared package/header: BASE_ADDR default, register offsets (OFF_VALUE=0, OFF_CTRL=4, OFF_STATUS=8), FSM state encodings (ST_IDLE, ST_PEND), CTRL/STATUS bit indices.
//  One sub-module: tick_gen (parameter UPDATE_DIV; ports clk, rst, tick) holds the wrapping counter.
//  Decode, register file, FSM and read mux stay in the top.
//  data_display connects directly to the display driver input; no other logic sits in that path.
// TESTING (UPDATE_DIV=8 in the bench)
//  1. Reset: rst high 2 cycles -> data_display=0, a VALUE read returns 0, STATUS=0.
//  2. Store 32'hAB12_3456 to +0 -> within 8 cycles data_display=24'h123456, VALUE read = 32'h0012_3456, pending=1 before the commit and 0 after.
//  3. Three stores 1, 2, 3 within 3 cycles of each other, no tick between them -> display steps straight to 3; 1 and 2 never appear.
//  4. CTRL=1, store 24'd999 and wait 24 cycles -> display unchanged, pending=1. Then CTRL=0 -> display=999 on the next tick.
//  5. Store timed to coincide with a tick while pending holds 5, storing 7 -> display=5 that cycle, then 7 on the following tick.
//  6. Store to BASE_ADDR+12, and a load from it -> no state change, rdata=0. Asserting rst while in PEND -> display=0 and pending=0.

Source files
------------

// File: rtl/display_mmio_pkg.sv
// display_mmio_pkg: register map, FSM states and bit indices shared by the display MMIO block.
package display_mmio_pkg;
    localparam logic [31:0] DEF_BASE_ADDR = 32'hFFFF_FC60;
    localparam int OFF_VALUE = 0;
    localparam int OFF_CTRL = 4;
    localparam int OFF_STATUS = 8;
    localparam int CTRL_FREEZE = 0;
    localparam int STAT_PENDING = 0;
    localparam int STAT_TICK_SEEN = 1;
    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;
endpackage

// File: rtl/display_mmio_if.sv
// display_mmio_if: CPU load/store bus plus the display output of the MMIO block.
interface display_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic we;
    logic re;
    logic [23:0] data_display;
    modport master (output addr, wdata, we, re, input rdata, data_display);
    modport slave (input addr, wdata, we, re, output rdata, data_display);
endinterface

// File: rtl/display_mmio_reg_tick_gen.sv
// tick_gen: free-running 0..UPDATE_DIV-1 counter, tick high on the last count.
module tick_gen #(
    parameter int UPDATE_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(UPDATE_DIV);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(UPDATE_DIV - 1);
    always_ff @(posedge clk)
        cnt <= (rst || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_mmio_reg.sv
// display_mmio_reg: CPU-visible shadow register pushed to the display only on refresh ticks,
// with freeze control and a sticky commit flag in STATUS.
module display_mmio_reg
    import display_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int UPDATE_DIV = 100_000
) (
    input logic clk,
    input logic rst,
    display_mmio_if.slave bus
);
    logic tick, freeze, tick_seen, commit, pending;
    logic hit_v, hit_c, hit_s, wr_v, rd_s;
    logic [23:0] shadow, display;
    logic [31:0] rdata;
    logic [29:0] word;
    logic unused;
    state_t state, state_nx;

    tick_gen #(.UPDATE_DIV(UPDATE_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign word = bus.addr[31:2] - BASE_ADDR[31:2];
    assign hit_v = word == 30'(OFF_VALUE / 4);
    assign hit_c = word == 30'(OFF_CTRL / 4);
    assign hit_s = word == 30'(OFF_STATUS / 4);
    assign wr_v = bus.we && hit_v;
    assign rd_s = bus.re && hit_s;
    assign pending = state == ST_PEND;
    assign unused = ^{bus.wdata[31:24], bus.addr[1:0]};

    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nx;

    // A store landing on the commit cycle re-arms PEND for the new value.
    always_comb
        state_nx = wr_v ? ST_PEND : commit ? ST_IDLE : state;

    always_comb
        commit = pending && tick && !freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            display <= '0;
            freeze <= 1'b0;
            tick_seen <= 1'b0;
            rdata <= '0;
        end else begin
            if (wr_v) shadow <= bus.wdata[23:0];
            if (bus.we && hit_c) freeze <= bus.wdata[CTRL_FREEZE];
            if (commit) display <= shadow;
            tick_seen <= commit || (tick_seen && !rd_s);
            rdata <= !bus.re ? '0 :
                     hit_v ? {8'h0, shadow} :
                     hit_c ? 32'(freeze) << CTRL_FREEZE :
                     hit_s ? (32'(tick_seen) << STAT_TICK_SEEN) | (32'(pending) << STAT_PENDING) :
                     '0;
        end
    end

    assign bus.rdata = rdata;
    assign bus.data_display = display;
endmodule

// File: tb/tb_display_mmio_reg.sv
// tb_display_mmio_reg: directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_display_mmio_reg;
    localparam logic [31:0] BASE = 32'hFFFF_FC60;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    display_mmio_if bus ();
    display_mmio_reg #(.BASE_ADDR(BASE), .UPDATE_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Model: cycle count since reset decides ticks; registers are plain variables.
    int m_cyc = 0;
    logic [23:0] m_shadow = '0, m_display = '0;
    logic [31:0] m_rdata = '0;
    bit m_freeze = 0, m_pending = 0, m_seen = 0;
    int m_k;
    bit m_tick, m_commit;
    logic [31:0] m_off;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0;
            m_shadow = '0;
            m_display = '0;
            m_rdata = '0;
            m_freeze = 0;
            m_pending = 0;
            m_seen = 0;
        end else begin
            m_off = (bus.addr >> 2) - (BASE >> 2);
            m_k = (m_off < 3) ? int'(m_off) : 3;
            m_tick = (m_cyc % DIV) == DIV - 1;
            m_commit = m_pending && m_tick && !m_freeze;
            m_rdata = !bus.re ? 32'h0 :
                      m_k == 0 ? {8'h0, m_shadow} :
                      m_k == 1 ? {31'h0, m_freeze} :
                      m_k == 2 ? {30'h0, m_seen, m_pending} : 32'h0;
            if (m_commit) begin
                m_display = m_shadow;
                m_pending = 0;
            end
            if (bus.we && m_k == 0) begin
                m_shadow = bus.wdata[23:0];
                m_pending = 1;
            end
            if (bus.we && m_k == 1) m_freeze = bus.wdata[0];
            m_seen = m_commit || (m_seen && !(bus.re && m_k == 2));
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk += 2;
            if (bus.data_display !== m_display) begin
                n_fail++;
                $display("FAIL model_display t=%0t: got %h expected %h", $time, bus.data_display, m_display);
            end
            if (bus.rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL model_rdata t=%0t: got %h expected %h", $time, bus.rdata, m_rdata);
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        bus.addr = a;
        bus.wdata = d;
        bus.we = 1'b1;
        bus.re = 1'b0;
        cyc();
        idle();
    endtask

    task automatic rd(logic [31:0] a);
        bus.addr = a;
        bus.re = 1'b1;
        bus.we = 1'b0;
        cyc();
        idle();
    endtask

    task automatic wait_disp(string name, logic [23:0] v, int lim);
        int i = 0;
        while (bus.data_display !== v && i < lim) begin
            cyc();
            i++;
        end
        check(name, {8'h0, bus.data_display}, {8'h0, v});
    endtask

    task automatic align(int phase);
        while ((m_cyc % DIV) != phase) cyc();
    endtask

    initial begin
        int sel;
        bus.addr = BASE;
        bus.wdata = '0;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_display", {8'h0, bus.data_display}, 32'h0);
        rd(BASE);
        check("reset_value", bus.rdata, 32'h0);
        rd(BASE + 8);
        check("reset_status", bus.rdata, 32'h0);

        align(0);
        wr(BASE, 32'hAB12_3456);
        rd(BASE + 8);
        check("pend_before", bus.rdata, 32'h1);
        rd(BASE);
        check("value_read", bus.rdata, 32'h0012_3456);
        wait_disp("commit_123456", 24'h123456, 8);
        rd(BASE + 8);
        check("status_after", bus.rdata, 32'h2);
        rd(BASE + 8);
        check("seen_cleared", bus.rdata, 32'h0);

        align(0);
        wr(BASE, 1);
        wr(BASE, 2);
        wr(BASE, 3);
        for (int i = 0; i < DIV; i++) begin
            check("no_intermediate", 32'(bus.data_display == 24'd1 || bus.data_display == 24'd2), 32'h0);
            cyc();
        end
        check("display_3", {8'h0, bus.data_display}, 32'd3);

        wr(BASE + 4, 1);
        wr(BASE, 999);
        repeat (24) cyc();
        check("frozen_display", {8'h0, bus.data_display}, 32'd3);
        rd(BASE + 8);
        check("frozen_status", bus.rdata, 32'h3);
        rd(BASE + 4);
        check("ctrl_read", bus.rdata, 32'h1);
        wr(BASE + 4, 0);
        wait_disp("unfreeze_999", 24'd999, DIV + 1);

        align(0);
        wr(BASE, 5);
        align(DIV - 1);
        wr(BASE, 7);
        check("collide_old", {8'h0, bus.data_display}, 32'd5);
        rd(BASE + 8);
        check("collide_status", bus.rdata, 32'h3);
        wait_disp("collide_new", 24'd7, DIV);

        wr(BASE + 12, 32'hDEAD_BEEF);
        rd(BASE + 12);
        check("miss_rdata", bus.rdata, 32'h0);
        rd(BASE);
        check("miss_value", bus.rdata, 32'h7);
        rd(BASE + 4);
        check("miss_ctrl", bus.rdata, 32'h0);
        wr(BASE, 32'h55);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_display", {8'h0, bus.data_display}, 32'h0);
        rd(BASE + 8);
        check("rst_status", bus.rdata, 32'h0);

        for (int i = 0; i < 800; i++) begin
            rst = $urandom_range(0, 199) == 0;
            bus.we = $urandom_range(0, 3) == 0;
            bus.re = $urandom_range(0, 2) == 0;
            sel = $urandom_range(0, 4);
            bus.addr = sel < 4 ? BASE + 32'(4 * sel) + 32'($urandom_range(0, 3)) : $urandom;
            bus.wdata = $urandom;
            if (sel == 1) bus.wdata[0] = $urandom_range(0, 3) == 0;
            cyc();
        end
        idle();
        rst = 1'b0;
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
